// File: rtl/sha256_message_unpad.sv
// rtl/sha256_message_unpad.sv - strips SHA-256 padding from 512-bit blocks and reports the message length
// Optional pad-content checking is enabled by defining SHA256_UNPAD_STRICT_EN.
module sha256_message_unpad #(
   parameter int ID_W  = 6,
   parameter int CNT_W = 55
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sync_rst,
   input  logic [511:0]      data_in,
   input  logic [ID_W-1:0]   data_in_id,
   input  logic              data_in_last,
   input  logic              data_in_valid,
   output logic              data_in_ready,
   output logic [511:0]      data_out,
   output logic [ID_W-1:0]   data_out_id,
   output logic              data_out_last,
   output logic              data_out_valid,
   input  logic              data_out_ready,
   output logic [63:0]       cfg_out_size,
   output logic [ID_W-1:0]   cfg_out_id,
   output logic              cfg_out_error,
   output logic              cfg_out_valid,
   input  logic              cfg_out_ready
);

   typedef enum logic [1:0] {S_COLLECT, S_DECODE, S_FLUSH, S_CFG} state_t;

   localparam logic [511:0] ONES = '1;

   state_t            r_state, w_state_nxt;

   logic [511:0]      r_a_data, r_b_data, w_a_data_nxt, w_b_data_nxt;
   logic [ID_W-1:0]   r_a_id, r_b_id, w_a_id_nxt, w_b_id_nxt;
   logic [1:0]        r_buf_cnt, w_buf_cnt_nxt;
   logic [1:0]        r_emit_n, w_emit_n_nxt;
   logic [511:0]      r_mask, w_mask_nxt;
   logic [CNT_W-1:0]  r_blk_cnt, w_blk_cnt_nxt;
   logic              r_err, w_err_nxt;
   logic [ID_W-1:0]   r_first_id, w_first_id_nxt;
   logic [63:0]       r_size, w_size_nxt;

   logic [511:0]      w_dout_nxt;
   logic [ID_W-1:0]   w_dout_id_nxt;
   logic              w_dout_last_nxt, w_dout_valid_nxt, w_din_ready_nxt;
   logic [63:0]       w_cfg_size_nxt;
   logic [ID_W-1:0]   w_cfg_id_nxt;
   logic              w_cfg_err_nxt, w_cfg_valid_nxt;

   logic              w_acc, w_out_free, w_cfg_hs;

   // Decode of the final block; only meaningful while in S_DECODE.
   logic [511:0]      w_newest, w_mark_blk, w_dec_mask;
   logic [63:0]       w_s;
   logic [8:0]        w_rem, w_mpos;
   logic [64:0]       w_e, w_p;
   logic              w_pad_only, w_cnt_err, w_mark_err, w_strict_err;

   assign w_acc      = data_in_valid && data_in_ready;
   assign w_out_free = !data_out_valid || data_out_ready;
   assign w_cfg_hs   = cfg_out_valid && cfg_out_ready;

   assign w_newest   = (r_buf_cnt == 2'd2) ? r_b_data : r_a_data;
   assign w_s        = w_newest[63:0];
   assign w_rem      = w_s[8:0];
   assign w_mpos     = 9'd511 - w_rem;
   assign w_e        = ({1'b0, w_s} + 65'd576) >> 9;
   assign w_p        = ({1'b0, w_s} + 65'd511) >> 9;
   assign w_pad_only = (w_e == w_p + 65'd1);
   assign w_cnt_err  = ({{(65-CNT_W){1'b0}}, r_blk_cnt} != w_e);
   // With a non-zero remainder and a pad-only tail, the marker sits in the older block.
   assign w_mark_blk = (w_pad_only && w_rem != 9'd0) ? r_a_data : w_newest;
   assign w_mark_err = !w_mark_blk[w_mpos];
   assign w_dec_mask = (w_cnt_err || w_rem == 9'd0) ? ONES
                                                    : (ONES << (10'd512 - {1'b0, w_rem}));

`ifdef SHA256_UNPAD_STRICT_EN
   localparam logic [511:0] HI_MASK = {{448{1'b1}}, 64'd0};
   logic [511:0] w_below;
   assign w_below = ~(ONES << w_mpos);
   always_comb begin
      if (w_pad_only && w_rem != 9'd0)
         w_strict_err = (|(r_a_data & w_below)) || (|(w_newest & HI_MASK));
      else
         w_strict_err = |(w_newest & w_below & HI_MASK);
   end
`else
   assign w_strict_err = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_COLLECT;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_COLLECT: if (w_acc && data_in_last) w_state_nxt = S_DECODE;
         S_DECODE:  w_state_nxt = S_FLUSH;
         S_FLUSH:   if (r_emit_n == 2'd0) w_state_nxt = S_CFG;
         S_CFG:     if (w_cfg_hs) w_state_nxt = S_COLLECT;
         default:   w_state_nxt = S_COLLECT;
      endcase
      if (sync_rst)
         w_state_nxt = S_COLLECT;
   end

   always_comb begin
      w_a_data_nxt     = r_a_data;
      w_b_data_nxt     = r_b_data;
      w_a_id_nxt       = r_a_id;
      w_b_id_nxt       = r_b_id;
      w_buf_cnt_nxt    = r_buf_cnt;
      w_emit_n_nxt     = r_emit_n;
      w_mask_nxt       = r_mask;
      w_blk_cnt_nxt    = r_blk_cnt;
      w_err_nxt        = r_err;
      w_first_id_nxt   = r_first_id;
      w_size_nxt       = r_size;
      w_dout_nxt       = data_out;
      w_dout_id_nxt    = data_out_id;
      w_dout_last_nxt  = data_out_last;
      w_dout_valid_nxt = data_out_valid && !data_out_ready;
      w_cfg_size_nxt   = cfg_out_size;
      w_cfg_id_nxt     = cfg_out_id;
      w_cfg_err_nxt    = cfg_out_error;
      w_cfg_valid_nxt  = cfg_out_valid && !cfg_out_ready;

      case (r_state)
         S_COLLECT: begin
            if (w_acc) begin
               w_blk_cnt_nxt = r_blk_cnt + 1'b1;
               if (r_blk_cnt == '0)
                  w_first_id_nxt = data_in_id;
               else if (data_in_id != r_first_id)
                  w_err_nxt = 1'b1;
               case (r_buf_cnt)
                  2'd0: begin
                     w_a_data_nxt  = data_in;
                     w_a_id_nxt    = data_in_id;
                     w_buf_cnt_nxt = 2'd1;
                  end
                  2'd1: begin
                     w_b_data_nxt  = data_in;
                     w_b_id_nxt    = data_in_id;
                     w_buf_cnt_nxt = 2'd2;
                  end
                  default: begin
                     // Anything older than the last two blocks is plain payload.
                     w_dout_nxt       = r_a_data;
                     w_dout_id_nxt    = r_a_id;
                     w_dout_last_nxt  = 1'b0;
                     w_dout_valid_nxt = 1'b1;
                     w_a_data_nxt     = r_b_data;
                     w_a_id_nxt       = r_b_id;
                     w_b_data_nxt     = data_in;
                     w_b_id_nxt       = data_in_id;
                  end
               endcase
            end
         end
         S_DECODE: begin
            w_size_nxt   = w_s;
            w_mask_nxt   = w_dec_mask;
            w_err_nxt    = r_err || w_cnt_err || (!w_cnt_err && (w_mark_err || w_strict_err));
            w_emit_n_nxt = w_cnt_err ? r_buf_cnt : (r_buf_cnt - {1'b0, w_pad_only});
         end
         S_FLUSH: begin
            if (r_emit_n != 2'd0) begin
               if (w_out_free) begin
                  w_dout_nxt       = r_a_data & ((r_emit_n == 2'd1) ? r_mask : ONES);
                  w_dout_id_nxt    = r_a_id;
                  w_dout_last_nxt  = (r_emit_n == 2'd1);
                  w_dout_valid_nxt = 1'b1;
                  w_a_data_nxt     = r_b_data;
                  w_a_id_nxt       = r_b_id;
                  w_emit_n_nxt     = r_emit_n - 2'd1;
               end
            end else begin
               w_buf_cnt_nxt   = 2'd0;
               w_cfg_size_nxt  = r_size;
               w_cfg_id_nxt    = r_first_id;
               w_cfg_err_nxt   = r_err;
               w_cfg_valid_nxt = 1'b1;
            end
         end
         S_CFG: begin
            if (w_cfg_hs) begin
               w_blk_cnt_nxt = '0;
               w_err_nxt     = 1'b0;
            end
         end
         default: ;
      endcase

      // A full buffer only accepts when A is guaranteed an empty output slot.
      w_din_ready_nxt = (w_state_nxt == S_COLLECT) &&
                        ((w_buf_cnt_nxt != 2'd2) || !w_dout_valid_nxt);

      if (sync_rst) begin
         w_a_data_nxt     = '0;
         w_b_data_nxt     = '0;
         w_a_id_nxt       = '0;
         w_b_id_nxt       = '0;
         w_buf_cnt_nxt    = 2'd0;
         w_emit_n_nxt     = 2'd0;
         w_mask_nxt       = '0;
         w_blk_cnt_nxt    = '0;
         w_err_nxt        = 1'b0;
         w_first_id_nxt   = '0;
         w_size_nxt       = '0;
         w_dout_nxt       = '0;
         w_dout_id_nxt    = '0;
         w_dout_last_nxt  = 1'b0;
         w_dout_valid_nxt = 1'b0;
         w_din_ready_nxt  = 1'b0;
         w_cfg_size_nxt   = '0;
         w_cfg_id_nxt     = '0;
         w_cfg_err_nxt    = 1'b0;
         w_cfg_valid_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_data       <= '0;
         r_b_data       <= '0;
         r_a_id         <= '0;
         r_b_id         <= '0;
         r_buf_cnt      <= 2'd0;
         r_emit_n       <= 2'd0;
         r_mask         <= '0;
         r_blk_cnt      <= '0;
         r_err          <= 1'b0;
         r_first_id     <= '0;
         r_size         <= '0;
         data_out       <= '0;
         data_out_id    <= '0;
         data_out_last  <= 1'b0;
         data_out_valid <= 1'b0;
         data_in_ready  <= 1'b0;
         cfg_out_size   <= '0;
         cfg_out_id     <= '0;
         cfg_out_error  <= 1'b0;
         cfg_out_valid  <= 1'b0;
      end else begin
         r_a_data       <= w_a_data_nxt;
         r_b_data       <= w_b_data_nxt;
         r_a_id         <= w_a_id_nxt;
         r_b_id         <= w_b_id_nxt;
         r_buf_cnt      <= w_buf_cnt_nxt;
         r_emit_n       <= w_emit_n_nxt;
         r_mask         <= w_mask_nxt;
         r_blk_cnt      <= w_blk_cnt_nxt;
         r_err          <= w_err_nxt;
         r_first_id     <= w_first_id_nxt;
         r_size         <= w_size_nxt;
         data_out       <= w_dout_nxt;
         data_out_id    <= w_dout_id_nxt;
         data_out_last  <= w_dout_last_nxt;
         data_out_valid <= w_dout_valid_nxt;
         data_in_ready  <= w_din_ready_nxt;
         cfg_out_size   <= w_cfg_size_nxt;
         cfg_out_id     <= w_cfg_id_nxt;
         cfg_out_error  <= w_cfg_err_nxt;
         cfg_out_valid  <= w_cfg_valid_nxt;
      end
   end

endmodule
